vanilla_remote_load_wb: RTL and testbench

Writeback buffer for remote load responses returning from the network endpoint to the vanilla core. It holds up to `els_p` `remote_load_resp_s` entries in arrival order. For each entry it extracts and sign- or zero-extends the byte, half-word or word, then presents it as a writeback request to either the integer or the FP regfile port. It sits between the endpoint's load-response output and the core's WB-stage regfile write arbitration, where pipeline writes have priority.

---
 rtl/vanilla_remote_load_wb.sv | 155 +++++++++++++++
 tb/tb_vanilla_remote_load_wb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_remote_load_wb.sv
// rtl/vanilla_remote_load_wb.sv - in-order writeback buffer for remote load responses
//
// Purpose:
//    Buffers up to els_p remote load responses in arrival order and presents
//    the head entry as a writeback request to either the integer regfile port
//    (with byte/half-word extraction and sign/zero extension) or the FP
//    regfile port (raw word).
//
// Ports:
//    clk_i, reset_n_i         clock, synchronous active-low reset
//    v_i, resp_i, ready_o     response input; transfer when v_i & ready_o
//                             resp_i = {float_wb, reg_id, is_unsigned_op,
//                                       is_byte_op, is_hex_op, part_sel[1:0], data}
//    int_wb_v_o/rd_o/data_o   integer writeback request, int_wb_yumi_i consumes it
//    float_wb_v_o/rd_o/data_o FP writeback request, float_wb_yumi_i consumes it
//    empty_o                  no entries held

module vanilla_remote_load_wb #(
   parameter int els_p          = 2,
   parameter int data_width_p   = 32,
   parameter int reg_id_width_p = 5
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic                                   v_i,
   input  logic [reg_id_width_p+data_width_p+5:0] resp_i,
   output logic                                   ready_o,
   output logic                                   int_wb_v_o,
   output logic [reg_id_width_p-1:0]              int_wb_rd_o,
   output logic [data_width_p-1:0]                int_wb_data_o,
   input  logic                                   int_wb_yumi_i,
   output logic                                   float_wb_v_o,
   output logic [reg_id_width_p-1:0]              float_wb_rd_o,
   output logic [data_width_p-1:0]                float_wb_data_o,
   input  logic                                   float_wb_yumi_i,
   output logic                                   empty_o
);

   localparam int RW    = reg_id_width_p + data_width_p + 6;
   localparam int CW    = $clog2(els_p + 1);
   // Storage is sized to the full pointer range so indexing needs no width fixups;
   // only the first els_p slots are ever used.
   localparam int DEPTH = 1 << CW;

   localparam logic [CW-1:0] LP_ELS  = CW'(els_p);
   localparam logic [CW-1:0] LP_LAST = CW'(els_p - 1);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   // Field positions inside a packed response
   localparam int F_FLOAT = RW - 1;
   localparam int F_RD    = RW - 2;
   localparam int F_UNS   = data_width_p + 4;
   localparam int F_BYTE  = data_width_p + 3;
   localparam int F_HEX   = data_width_p + 2;
   localparam int F_PS    = data_width_p;

   logic [RW-1:0]           r_mem [DEPTH];
   logic [CW-1:0]           r_rptr;
   logic [CW-1:0]           r_wptr;
   logic [CW-1:0]           r_cnt;
   logic                    r_in_reset;

   logic                    w_enq;
   logic                    w_deq;
   logic                    w_nonempty;
   logic [RW-1:0]           w_head;
   logic                    w_head_float;
   logic [reg_id_width_p-1:0] w_head_rd;
   logic [data_width_p-1:0] w_head_data;
   logic [1:0]              w_head_ps;
   logic [7:0]              w_byte;
   logic [15:0]             w_hex;
   logic [data_width_p-1:0] w_int_data;

   // ready_o comes only from registered state: held low for the cycle after a
   // reset edge, and low whenever the buffer is full (even if a yumi arrives).
   assign ready_o    = !r_in_reset && (r_cnt < LP_ELS);
   assign w_nonempty = (r_cnt != '0);
   assign empty_o    = !w_nonempty;
   assign w_enq      = v_i && ready_o;

   assign w_head       = r_mem[r_rptr];
   assign w_head_float = w_head[F_FLOAT];
   assign w_head_rd    = w_head[F_RD -: reg_id_width_p];
   assign w_head_data  = w_head[data_width_p-1:0];
   assign w_head_ps    = w_head[F_PS +: 2];

   assign int_wb_v_o   = w_nonempty && !w_head_float;
   assign float_wb_v_o = w_nonempty &&  w_head_float;

   // A yumi without its matching valid is ignored rather than popping the head.
   assign w_deq = (int_wb_yumi_i && int_wb_v_o) || (float_wb_yumi_i && float_wb_v_o);

   always_comb begin
      w_byte = w_head_data[7:0];
      case (w_head_ps)
         2'd0:    w_byte = w_head_data[7:0];
         2'd1:    w_byte = w_head_data[15:8];
         2'd2:    w_byte = w_head_data[23:16];
         default: w_byte = w_head_data[31:24];
      endcase
   end

   assign w_hex = w_head_ps[1] ? w_head_data[31:16] : w_head_data[15:0];

   // Byte takes precedence over half-word when both flags are set.
   always_comb begin
      w_int_data = w_head_data;
      if (w_head[F_BYTE]) begin
         w_int_data = {{(data_width_p-8){w_byte[7] && !w_head[F_UNS]}}, w_byte};
      end else if (w_head[F_HEX]) begin
         w_int_data = {{(data_width_p-16){w_hex[15] && !w_head[F_UNS]}}, w_hex};
      end
   end

   assign int_wb_rd_o     = int_wb_v_o   ? w_head_rd   : '0;
   assign int_wb_data_o   = int_wb_v_o   ? w_int_data  : '0;
   assign float_wb_rd_o   = float_wb_v_o ? w_head_rd   : '0;
   assign float_wb_data_o = float_wb_v_o ? w_head_data : '0;

   // Payload storage is intentionally not reset; occupancy alone marks validity.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_wptr] <= resp_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_rptr     <= '0;
         r_wptr     <= '0;
         r_cnt      <= '0;
         r_in_reset <= 1'b1;
      end else begin
         r_in_reset <= 1'b0;
         if (w_enq) begin
            r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + LP_ONE;
         end
         if (w_deq) begin
            r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + LP_ONE;
         end
         case ({w_enq, w_deq})
            2'b10:   r_cnt <= r_cnt + LP_ONE;
            2'b01:   r_cnt <= r_cnt - LP_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   a_int_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      int_wb_yumi_i |-> int_wb_v_o);
   a_float_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      float_wb_yumi_i |-> float_wb_v_o);

endmodule

// File: tb/tb_vanilla_remote_load_wb.sv
// tb/tb_vanilla_remote_load_wb.sv - self-checking bench for vanilla_remote_load_wb

module tb_vanilla_remote_load_wb;

   localparam int ELS = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        v;
   logic [42:0] resp;
   logic        ready;
   logic        int_v, flt_v, empty;
   logic [4:0]  int_rd, flt_rd;
   logic [31:0] int_data, flt_data;
   logic        int_yumi, flt_yumi;

   int n_vec = 0;
   int n_err = 0;

   logic [42:0] mq[$];
   bit          m_rst;

   logic [77:0] got;
   logic [77:0] exp;

   always #5 clk = ~clk;

   vanilla_remote_load_wb #(.els_p(ELS), .data_width_p(32), .reg_id_width_p(5)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .resp_i(resp), .ready_o(ready),
      .int_wb_v_o(int_v), .int_wb_rd_o(int_rd), .int_wb_data_o(int_data),
      .int_wb_yumi_i(int_yumi),
      .float_wb_v_o(flt_v), .float_wb_rd_o(flt_rd), .float_wb_data_o(flt_data),
      .float_wb_yumi_i(flt_yumi), .empty_o(empty)
   );

   assign got = {int_v, int_rd, int_data, flt_v, flt_rd, flt_data, ready, empty};

   function automatic logic [42:0] mk(bit flt, logic [4:0] rd, bit uns, bit byt,
                                      bit hex, logic [1:0] ps, logic [31:0] d);
      return {flt, rd, uns, byt, hex, ps, d};
   endfunction

   // Integer formatting from the rules, using plain arithmetic
   function automatic logic [31:0] fmt_int(logic [42:0] r);
      longint val;
      longint d;
      int     ps;
      d  = longint'({32'b0, r[31:0]});
      ps = int'(r[33:32]);
      if (r[35]) begin
         val = (d / (longint'(1) << (8 * ps))) % 256;
         if (!r[36] && val >= 128) val = val - 256;
      end else if (r[34]) begin
         val = (d / (longint'(1) << (16 * (ps / 2)))) % 65536;
         if (!r[36] && val >= 32768) val = val - 65536;
      end else begin
         val = d;
      end
      return val[31:0];
   endfunction

   function automatic logic [77:0] model_exp();
      logic        iv, fv, rdy, emp;
      logic [4:0]  ird, frd;
      logic [31:0] idat, fdat;
      logic [42:0] h;
      iv = 0; fv = 0; ird = 0; frd = 0; idat = 0; fdat = 0;
      if (mq.size() > 0) begin
         h = mq[0];
         if (h[42]) begin fv = 1; frd = h[41:37]; fdat = h[31:0]; end
         else begin iv = 1; ird = h[41:37]; idat = fmt_int(h); end
      end
      rdy = !m_rst && (mq.size() < ELS);
      emp = (mq.size() == 0);
      return {iv, ird, idat, fv, frd, fdat, rdy, emp};
   endfunction

   // Advance one clock and update the reference queue with what the edge should do
   task automatic cycle();
      bit rdy;
      bit deq;
      rdy = !m_rst && (mq.size() < ELS);
      deq = (mq.size() > 0) && ((int_yumi && !mq[0][42]) || (flt_yumi && mq[0][42]));
      @(posedge clk);
      if (!reset_n) begin
         mq.delete();
         m_rst = 1;
      end else begin
         m_rst = 0;
         if (deq) void'(mq.pop_front());
         if (v && rdy) mq.push_back(resp);
      end
      #1;
   endtask

   task automatic idle();
      v = 0; int_yumi = 0; flt_yumi = 0;
   endtask

   task automatic test_reset();
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL reset_held got=%h exp=%h", got, exp); end
      n_vec++;
      if (ready !== 1'b0 || empty !== 1'b1) begin
         n_err++; $display("FAIL reset_ready_empty got=%b%b exp=01", ready, empty);
      end
      reset_n = 1;
      cycle();
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
      n_vec++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got=%b exp=1", ready); end
   endtask

   task automatic test_signed_byte();
      v = 1; resp = mk(0, 5, 0, 1, 0, 2, 32'h1280_3456);
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL sbyte_no_bypass got=%h exp=%h", got, exp); end
      cycle();
      idle();
      n_vec++;
      if ({int_v, int_rd, int_data} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin
         n_err++; $display("FAIL sbyte_head got=%b/%0d/%h exp=1/5/ffffff80", int_v, int_rd, int_data);
      end
      int_yumi = 1;
      cycle();
      idle();
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL sbyte_empty got=%b exp=1", empty); end
   endtask

   task automatic test_hex();
      v = 1; resp = mk(0, 9, 1, 0, 1, 3, 32'hBEEF_0001);
      cycle();
      resp = mk(0, 10, 0, 0, 1, 0, 32'h0000_8001);
      cycle();
      idle();
      n_vec++;
      if (int_data !== 32'h0000_BEEF) begin n_err++; $display("FAIL uhex got=%h exp=0000beef", int_data); end
      int_yumi = 1;
      cycle();
      idle();
      n_vec++;
      if (int_data !== 32'hFFFF_8001 || int_rd !== 5'd10) begin
         n_err++; $display("FAIL shex got=%h/%0d exp=ffff8001/10", int_data, int_rd);
      end
      int_yumi = 1;
      cycle();
      idle();
   endtask

   task automatic test_mixed_order();
      v = 1; resp = mk(1, 3, 0, 1, 1, 1, 32'h3F80_0000);
      cycle();
      resp = mk(0, 7, 0, 0, 0, 0, 32'hDEAD_BEEF);
      cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({flt_v, flt_rd, flt_data, int_v, int_data} !== {1'b1, 5'd3, 32'h3F80_0000, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL mixed_float_stall got=%b/%0d/%h int_v=%b exp=1/3/3f800000 int_v=0",
                              flt_v, flt_rd, flt_data, int_v);
         end
         cycle();
      end
      flt_yumi = 1;
      cycle();
      idle();
      n_vec++;
      if ({int_v, int_rd, int_data, flt_v} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0}) begin
         n_err++; $display("FAIL mixed_int got=%b/%0d/%h flt_v=%b exp=1/7/deadbeef/0",
                           int_v, int_rd, int_data, flt_v);
      end
      int_yumi = 1;
      cycle();
      idle();
   endtask

   task automatic test_full();
      v = 1; resp = mk(0, 1, 0, 0, 0, 0, 32'h11);
      cycle();
      resp = mk(0, 2, 0, 0, 0, 0, 32'h22);
      cycle();
      v = 0;
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", ready); end
      v = 1; resp = mk(0, 3, 0, 0, 0, 0, 32'h33); int_yumi = 1;
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL full_drop_pre got=%h exp=%h", got, exp); end
      cycle();
      idle();
      n_vec++;
      if ({ready, int_rd, int_data} !== {1'b1, 5'd2, 32'h22}) begin
         n_err++; $display("FAIL full_drop got=%b/%0d/%h exp=1/2/22", ready, int_rd, int_data);
      end
      int_yumi = 1;
      cycle();
      idle();
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL full_third_dropped got=%b exp=1", empty); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 20; i++) begin
         v = (i < 20);
         resp = mk(0, 5'($urandom), 0, 0, 0, 2'($urandom), 32'(i));
         int_yumi = (i > 0);
         exp = model_exp(); n_vec++;
         if (got !== exp) begin n_err++; $display("FAIL stream[%0d] got=%h exp=%h", i, got, exp); end
         if (i > 0) begin
            n_vec++;
            if (int_data !== 32'(i - 1)) begin
               n_err++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, int_data, 32'(i - 1));
            end
         end
         cycle();
      end
      idle();
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL stream_empty got=%b exp=1", empty); end
   endtask

   task automatic test_reset_mid();
      v = 1; resp = mk(0, 4, 0, 0, 0, 0, 32'hAAAA_0001);
      cycle();
      resp = mk(1, 6, 0, 0, 0, 0, 32'hAAAA_0002);
      cycle();
      idle();
      reset_n = 0;
      cycle();
      reset_n = 1;
      n_vec++;
      if ({int_v, flt_v, empty, int_data, flt_data, int_rd, flt_rd} !== {3'b001, 74'h0}) begin
         n_err++; $display("FAIL midreset_clear got=%b%b%b %h %h exp=001 0 0",
                           int_v, flt_v, empty, int_data, flt_data);
      end
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL midreset_state got=%h exp=%h", got, exp); end
      cycle();
      n_vec++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready got=%b exp=1", ready); end
      v = 1; resp = mk(0, 8, 1, 1, 0, 1, 32'h0000_C300);
      cycle();
      idle();
      n_vec++;
      if ({int_v, int_rd, int_data} !== {1'b1, 5'd8, 32'h0000_00C3}) begin
         n_err++; $display("FAIL midreset_head got=%b/%0d/%h exp=1/8/000000c3", int_v, int_rd, int_data);
      end
      int_yumi = 1;
      cycle();
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         idle();
         reset_n = ($urandom_range(0, 59) != 0);
         v = $urandom_range(0, 1);
         resp = mk($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 2'($urandom), $urandom);
         if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
            if (mq[0][42]) flt_yumi = 1; else int_yumi = 1;
         end
         exp = model_exp(); n_vec++;
         if (got !== exp) begin n_err++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp); end
         cycle();
      end
      idle();
      reset_n = 1;
      cycle();
      exp = model_exp(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL random_end got=%h exp=%h", got, exp); end
   endtask

   initial begin
      reset_n = 0; v = 0; resp = '0; int_yumi = 0; flt_yumi = 0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();
      m_rst = 1;
      test_reset();
      test_signed_byte();
      test_hex();
      test_mixed_order();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
